// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with a byte FIFO in front of it.
// Ports: clk/rst (async active-high); tx_data/tx_valid/tx_ready push bytes into the FIFO;
//        uart_TX is the registered serial line, tx_busy flags a frame in flight, fifo_count is occupancy.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          tx_data,
  input  logic                                tx_valid,
  output logic                                tx_ready,
  output logic                                uart_TX,
  output logic                                tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int OCC_W        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift, shift_nxt;
  logic             bit_done, push, pop, empty, line_nxt;

  assign bit_done = (baud_cnt == BIT_LAST);
  assign empty    = (fifo_count == '0);
  assign tx_ready = (fifo_count != OCC_FULL);
  assign push     = tx_valid && tx_ready;
  // Pops only happen where the FSM is about to enter START.
  assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_done));

  // ---------------- FIFO storage and pointers ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The line is registered, so it is driven from the state and shift value
  // that will be current after this edge.
  always_comb begin
    line_nxt = 1'b1;
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
      default: line_nxt = 1'b1;
    endcase
    tx_busy = (state != IDLE);
  end

  always_comb begin
    shift_nxt = shift;
    if (pop)                           shift_nxt = mem[rd_ptr];
    else if (state == DATA && bit_done) shift_nxt = {1'b0, shift[7:1]};
  end

  // ---------------- bit timing and shifter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_TX  <= 1'b1;
    end else begin
      // Every state change coincides with bit_done or leaving IDLE, so this
      // also clears the counter on each state entry.
      baud_cnt <= (state == IDLE || bit_done) ? '0 : baud_cnt + CNT_W'(1);
      shift    <= shift_nxt;
      uart_TX  <= line_nxt;
      if (state == START)                 bit_idx <= '0;
      else if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule
